// File: rtl/ysyx_24110015_mem_pkg.sv
// Shared types and response codes for the memory responder.
package ysyx_24110015_mem_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRdWait,
      StRdResp,
      StWrWait,
      StWrResp
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_24110015_mem_array.sv
// Single-port word storage with byte strobes and a registered read port.
module ysyx_24110015_mem_array #(
   parameter int unsigned DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [31:0]              wdata,
   input  logic [3:0]               wstrb,
   output logic [31:0]              rdata
);

   logic [31:0] mem [DEPTH];
   logic [31:0] rdata_q;

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (en && we) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (en && !we) begin
         rdata_q <= mem[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/ysyx_24110015_mem_resp.sv
// Fixed-latency memory responder: valid/ready read and write channels in front of a word array.
module ysyx_24110015_mem_resp
   import ysyx_24110015_mem_pkg::*;
#(
   parameter logic [31:0] BASE    = 32'h8000_0000,
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        rvalid_q, rvalid_d;
   logic        bvalid_q, bvalid_d;
   logic [1:0]  rresp_q, rresp_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        rd_ok_q, rd_ok_d;
   logic        arready_q;

   logic [31:0] offset;
   logic        in_range;
   logic        wr_accept;
   logic        mem_en, mem_we;
   logic [31:0] mem_rdata;

   // Unsigned wrap makes addresses below BASE land far above SPAN.
   assign offset   = addr_q - BASE;
   assign in_range = offset < SPAN;

   // arready_q doubles as "idle and out of reset", keeping writes off during reset.
   assign wr_accept = arready_q && awvalid && wvalid && !arvalid;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      rvalid_d = rvalid_q;
      bvalid_d = bvalid_q;
      rresp_d  = rresp_q;
      bresp_d  = bresp_q;
      rd_ok_d  = rd_ok_q;
      mem_en   = 1'b0;
      mem_we   = 1'b0;
      case (state_q)
         StIdle: begin
            if (arvalid && arready_q) begin
               addr_d  = araddr;
               cnt_d   = CNT_INIT;
               state_d = StRdWait;
            end else if (wr_accept) begin
               addr_d  = awaddr;
               wdata_d = wdata;
               wstrb_d = wstrb;
               cnt_d   = CNT_INIT;
               state_d = StWrWait;
            end
         end
         StRdWait: begin
            if (cnt_q == '0) begin
               mem_en   = in_range;
               rd_ok_d  = in_range;
               rresp_d  = in_range ? RESP_OKAY : RESP_SLVERR;
               rvalid_d = 1'b1;
               state_d  = StRdResp;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StRdResp: begin
            if (rready) begin
               rvalid_d = 1'b0;
               state_d  = StIdle;
            end
         end
         StWrWait: begin
            if (cnt_q == '0) begin
               mem_en   = in_range;
               mem_we   = in_range;
               bresp_d  = in_range ? RESP_OKAY : RESP_SLVERR;
               bvalid_d = 1'b1;
               state_d  = StWrResp;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StWrResp: begin
            if (bready) begin
               bvalid_d = 1'b0;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rvalid_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         bresp_q   <= RESP_OKAY;
         rd_ok_q   <= 1'b0;
         arready_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rvalid_q  <= rvalid_d;
         bvalid_q  <= bvalid_d;
         rresp_q   <= rresp_d;
         bresp_q   <= bresp_d;
         rd_ok_q   <= rd_ok_d;
         arready_q <= (state_d == StIdle);
      end
   end

   ysyx_24110015_mem_array #(
      .DEPTH(DEPTH)
   ) u_array (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (mem_en),
      .we   (mem_we),
      .addr (offset[AW+1:2]),
      .wdata(wdata_q),
      .wstrb(wstrb_q),
      .rdata(mem_rdata)
   );

   assign arready = arready_q;
   assign awready = wr_accept;
   assign wready  = wr_accept;
   assign rvalid  = rvalid_q;
   assign rresp   = rresp_q;
   assign rdata   = rd_ok_q ? mem_rdata : 32'h0;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;

endmodule

// File: tb/tb_ysyx_24110015_mem_resp.sv
// Directed bench for the memory responder with hand-computed expectations.
module tb_ysyx_24110015_mem_resp;

   localparam int unsigned LAT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b1;
   logic [31:0] awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b1;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   ysyx_24110015_mem_resp #(
      .BASE   (32'h8000_0000),
      .DEPTH  (1024),
      .LATENCY(LAT)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .araddr (araddr),
      .arvalid(arvalid),
      .arready(arready),
      .rdata  (rdata),
      .rresp  (rresp),
      .rvalid (rvalid),
      .rready (rready),
      .awaddr (awaddr),
      .awvalid(awvalid),
      .awready(awready),
      .wdata  (wdata),
      .wstrb  (wstrb),
      .wvalid (wvalid),
      .wready (wready),
      .bresp  (bresp),
      .bvalid (bvalid),
      .bready (bready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                          output int lat);
      int n = 0;
      araddr  = a;
      arvalid = 1'b1;
      while (!arready && n < 20) begin step(); n++; end
      if (!arready) check("arready_timeout", 32'(arready), 32'h1);
      step();
      arvalid = 1'b0;
      lat = 0;
      while (!rvalid && lat < 40) begin step(); lat++; end
      d = rdata;
      r = rresp;
      if (rready) step();
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r, output int lat);
      int n = 0;
      awaddr  = a;
      wdata   = d;
      wstrb   = s;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      while (!awready && n < 20) begin step(); n++; end
      if (!awready) check("awready_timeout", 32'(awready), 32'h1);
      step();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      lat = 0;
      while (!bvalid && lat < 40) begin step(); lat++; end
      r = bresp;
      if (bready) step();
   endtask

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;

      // Reset values
      step();
      step();
      check("rst_arready", 32'(arready), 32'h0);
      check("rst_rvalid", 32'(rvalid), 32'h0);
      check("rst_bvalid", 32'(bvalid), 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_resp", {28'h0, rresp, bresp}, 32'h0);
      rst_n = 1'b1;
      step();
      check("idle_arready", 32'(arready), 32'h1);

      // Basic write / readback and latency
      do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, r, lat);
      check("wr1_bresp", 32'(r), 32'h0);
      check("wr1_lat", 32'(lat), LAT);
      do_read(32'h8000_0010, d, r, lat);
      check("rd1_data", d, 32'hDEAD_BEEF);
      check("rd1_rresp", 32'(r), 32'h0);
      check("rd1_lat", 32'(lat), LAT);
      check("rd1_back_idle", 32'(arready), 32'h1);
      do_read(32'h8000_0013, d, r, lat);
      check("rd_lowbits_ign", d, 32'hDEAD_BEEF);

      // Byte strobes
      do_write(32'h8000_0040, 32'h1122_3344, 4'hF, r, lat);
      do_write(32'h8000_0040, 32'hAABB_CCDD, 4'b0101, r, lat);
      do_read(32'h8000_0040, d, r, lat);
      check("strb_merge", d, 32'h11BB_33DD);

      // Last word in range, then out-of-range on both channels
      do_write(32'h8000_0FFC, 32'hCAFE_0001, 4'hF, r, lat);
      check("last_bresp", 32'(r), 32'h0);
      do_read(32'h8000_0FFC, d, r, lat);
      check("last_data", d, 32'hCAFE_0001);
      do_write(32'h8000_0000, 32'h0BAD_F00D, 4'hF, r, lat);
      do_read(32'h7FFF_FFFC, d, r, lat);
      check("oor_rd_resp", 32'(r), 32'h2);
      check("oor_rd_data", d, 32'h0);
      check("oor_rd_lat", 32'(lat), LAT);
      do_write(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, r, lat);
      check("oor_wr_resp", 32'(r), 32'h2);
      do_read(32'h8000_0000, d, r, lat);
      check("oor_word0", d, 32'h0BAD_F00D);
      check("ok_after_oor", 32'(r), 32'h0);

      // Back-pressure on the read response
      rready = 1'b0;
      do_read(32'h8000_0010, d, r, lat);
      for (int i = 0; i < 5; i++) begin
         check("hold_rvalid", 32'(rvalid), 32'h1);
         check("hold_rdata", rdata, 32'hDEAD_BEEF);
         check("hold_arready", 32'(arready), 32'h0);
         step();
      end
      rready = 1'b1;
      step();
      check("hold_release_rvalid", 32'(rvalid), 32'h0);
      check("hold_release_idle", 32'(arready), 32'h1);

      // Simultaneous read and write: read wins, write follows
      araddr  = 32'h8000_0040;
      arvalid = 1'b1;
      awaddr  = 32'h8000_0080;
      wdata   = 32'h5566_7788;
      wstrb   = 4'hF;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      #1;
      check("prio_awready", 32'(awready), 32'h0);
      check("prio_wready", 32'(wready), 32'h0);
      check("prio_arready", 32'(arready), 32'h1);
      step();
      arvalid = 1'b0;
      #1;
      check("prio_busy_awready", 32'(awready), 32'h0);
      lat = 0;
      while (!rvalid && lat < 40) begin step(); lat++; end
      check("prio_rd_lat", 32'(lat), LAT);
      check("prio_rd_data", rdata, 32'h11BB_33DD);
      step();
      check("prio_wr_awready", 32'(awready), 32'h1);
      check("prio_wr_wready", 32'(wready), 32'h1);
      step();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      lat = 0;
      while (!bvalid && lat < 40) begin step(); lat++; end
      check("prio_wr_lat", 32'(lat), LAT);
      check("prio_wr_bresp", 32'(bresp), 32'h0);
      step();
      do_read(32'h8000_0080, d, r, lat);
      check("prio_wr_data", d, 32'h5566_7788);

      // Reset during WR_WAIT leaves the array untouched
      awaddr  = 32'h8000_0010;
      wdata   = 32'h0000_0000;
      wstrb   = 4'hF;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      #1;
      step();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      step();
      check("pre_rst_rdata", rdata, 32'h5566_7788);
      rst_n = 1'b0;
      #1;
      check("mid_rst_arready", 32'(arready), 32'h0);
      check("mid_rst_bvalid", 32'(bvalid), 32'h0);
      check("mid_rst_rdata", rdata, 32'h0);
      check("mid_rst_awready", 32'(awready), 32'h0);
      step();
      step();
      check("mid_rst_hold_bvalid", 32'(bvalid), 32'h0);
      rst_n = 1'b1;
      step();
      step();
      do_read(32'h8000_0010, d, r, lat);
      check("mid_rst_word", d, 32'hDEAD_BEEF);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/ysyx_24110015_mem_resp.md
# ysyx_24110015_mem_resp

Memory responder serving the fetch and load/store units: accepts single-beat read and write requests over valid/ready channels, models a fixed access latency, and returns data or a write acknowledgement with a response code. It sits on the other side of the core's memory interface and replaces the zero-latency SRAM, so that the IFU and LSU are exercised against real handshakes and wait states. It holds a word-addressed storage array with byte-strobe writes.

## Interface
- `BASE`, 32'h8000_0000, byte address of word 0
- `DEPTH`, 1024, number of 32-bit words; power of two
- `LATENCY`, 1, cycles from request acceptance to response valid; legal range 1..15
- `clk` in 1: clock, all state updates on the rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `araddr` in 32, `arvalid` in 1, `arready` out 1: read request channel
- `rdata` out 32, `rresp` out 2, `rvalid` out 1, `rready` in 1: read response channel
- `awaddr` in 32, `awvalid` in 1, `awready` out 1: write address channel
- `wdata` in 32, `wstrb` in 4, `wvalid` in 1, `wready` out 1: write data channel
- `bresp` out 2, `bvalid` out 1, `bready` in 1: write response channel

## Operation
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP.
- In IDLE, `arready`=1. In every other state, all readies are 0.
- In IDLE, `awready`=`wready`=(`awvalid` && `wvalid` && !`arvalid`). Both write channels complete together, and a read request has priority over a simultaneous write.
- Read accept (`arvalid`&&`arready`):
  - latch the address, load the counter with LATENCY-1, go to RD_WAIT.
  - When the counter is 0, capture the array word into `rdata`, set `rresp` and `rvalid`, then go to RD_RESP.
- Write accept: latch the address, data and strobe, load the counter, go to WR_WAIT.
  - When the counter is 0, write the bytes with `wstrb[i]`=1 (byte i = bits 8i+7:8i), set `bresp` and `bvalid`, then go to WR_RESP.
- RD_RESP and WR_RESP: hold `rdata`/`rresp` and `bresp` stable until `rready` or `bready` respectively; on that handshake, drop valid and return to IDLE.
- Address decode:
  - word index = (addr − BASE) >> 2; `addr[1:0]` is ignored.
  - In range iff (addr − BASE) < DEPTH*4, using unsigned 32-bit subtraction so that wrap-around below BASE counts as out of range.
  - Out of range: resp = SLVERR (2'b10), `rdata`=32'h0, and no array write.
  - In range: resp = OKAY (2'b00).
- Reset: `arready`=0 while `rst_n` is low, then 1 in IDLE. `awready`=`wready`=`rvalid`=`bvalid`=0, `rdata`=0, `rresp`=`bresp`=0, state=IDLE, counter=0. Array contents are not reset.
- Reset mid-transaction aborts it. A write whose counter has not yet reached 0 must leave the array unchanged.

## Timing
- Request accepted at edge T → response valid from edge T+LATENCY.
- Minimum occupancy is LATENCY+1 cycles per transaction when `rready`/`bready` is held high.
- A new request can be accepted in the cycle immediately after the response handshake.
- `arready` is a registered function of state only. `awready`/`wready` are combinational from the valids and state; no other combinational path runs from inputs to outputs.
- A write followed by a read to the same address returns the new data, because the write commits before `bvalid` rises.

## Structure
- Shared package `ysyx_24110015_mem_pkg`:
  - state enum
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10
- Sub-module `ysyx_24110015_mem_array`: single-port DEPTH×32 storage with byte strobes and a registered read.
- The FSM, latency counter and decode stay in the top module.

## Test plan
- Write 32'hDEAD_BEEF to 0x8000_0010 with strobe 4'hF, then read it back → `bresp`=0, then `rdata`=32'hDEAD_BEEF, `rresp`=0, with `rvalid` exactly LATENCY cycles after `arvalid`&&`arready`.
- Write 32'h1122_3344 with strobe 4'hF, then write 32'hAABB_CCDD with strobe 4'b0101 to the same word, then read → 32'h11BB_33DD.
- Read 0x7FFF_FFFC and write 0x8000_1000 (DEPTH=1024) → SLVERR on both, `rdata`=0, and a readback of word 0 is unchanged.
- Hold `rready`=0 for 5 cycles after `rvalid` → `rvalid`/`rdata` stay stable, `arready`=0 throughout; the handshake returns to IDLE next cycle.
- Assert `arvalid`, `awvalid` and `wvalid` in the same IDLE cycle → the read is accepted first with `awready`=0; the write is accepted after the read response handshake.
- Pull `rst_n` low during WR_WAIT with LATENCY=4 → all outputs return to reset values immediately, and a later read shows the target word unchanged.
